arbitro_memoria_dados: RTL and testbench
========================================

Name: arbitro_memoria_dados

Overview:
- Two-port arbiter sharing the single data memory port between requester 0 (processor load/store path) and requester 1 (auxiliary master: display scanner / I/O copy engine).
- Serialises accesses through a small FSM, registers the memory command, and returns read data to the winning requester with a valid pulse.
- Sits between the processor datapath and the data memory. The processor uses gnt0/rvalid0 to stall.

Parameters:
- ADDR_W, 8, byte address width of the data memory.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock (divided processor clock); all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- req0  in  1  requester 0 access request; held with fields stable until gnt0 or err0.
- we0  in  1  requester 0 write (1) / read (0).
- addr0  in  ADDR_W  requester 0 byte address.
- wdata0  in  DATA_W  requester 0 write data.
- type0  in  2  requester 0 access size: 00 byte, 01 half, 10 word, 11 reserved.
- gnt0  out  1  one-cycle pulse: requester 0 command is on the memory port this cycle.
- err0  out  1  one-cycle pulse: requester 0 request rejected.
- rvalid0  out  1  one-cycle pulse: rdata0 valid.
- rdata0  out  DATA_W  read data to requester 0.
- req1, we1, addr1, wdata1, type1, gnt1, err1, rvalid1, rdata1: same as above for requester 1.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wdata  out  DATA_W  registered write data.
- mem_type  out  2  registered access size.
- mem_we  out  1  write strobe, high one cycle.
- mem_re  out  1  read strobe, high one cycle.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_re (one-cycle synchronous read).
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset is sampled on posedge clk while reset==0.
  - All outputs go to 0, state goes to IDLE, and the round-robin pointer last goes to 1 (requester 0 wins first).
  - Reset during CMD or RWAIT aborts the access: no rvalid is issued and the captured read data is discarded.
- States:
  - IDLE
    - Sample req0 and req1 and pick a winner W.
    - If only one is requesting, it wins.
    - If both are requesting, the one not equal to last wins.
    - Validate W: reject type 11, type 01 with addr[0]=1, and type 10 with addr[1:0]!=0.
    - Invalid: pulse errW next cycle, no memory strobe, last<=W, stay IDLE.
    - Valid: register addr, wdata and type into mem_*; set mem_we=we or mem_re=~we; last<=W; go to CMD.
  - CMD
    - mem_* command and the matching strobe are visible, and gntW pulses this cycle.
    - Write: go to IDLE. Read: go to RWAIT.
    - Strobes clear on exit.
  - RWAIT
    - Capture mem_rdata into rdataW.
    - Go to IDLE with rvalidW=1 for exactly the first IDLE cycle.
- Latency from request sampled in IDLE at cycle T:
  - Write: gnt at T+1; next arbitration at T+2.
  - Read: gnt at T+1, rvalid at T+3; next arbitration at T+3, so the rvalid cycle overlaps a new sample.
  - Error: err at T+1; next arbitration at T+1.
- The loser keeps req high and is guaranteed service on the next arbitration under round-robin. Maximum wait is one transaction.
- A request deasserted before grant is dropped silently; the arbiter never issues an unrequested command.
- Requests arriving while busy=1 are ignored until IDLE.
- rdata0/rdata1 hold their last value between rvalid pulses.
- The losing requester's rdata is unchanged.
- mem_addr, mem_wdata and mem_type hold their last value in IDLE.
- Exactly one of gnt0, gnt1, err0, err1 may be high in any cycle.
- mem_we and mem_re are never both high.

Optional Feature:
- Macro PRIORIDADE_FIXA_CPU_EN.
- Defined: fixed priority. Requester 0 always wins when req0=1; requester 1 is served only in an IDLE cycle with req0=0. last is still updated but does not affect selection.
- Undefined: round-robin as described above.

Test Plan:
- Reset then single read: req0=1, we0=0, addr0=8'h10, type0=10, memory holds 32'hDEADBEEF at 0x10.
  -> gnt0 at T+1 with mem_re=1 and mem_addr=8'h10; rvalid0=1 and rdata0=32'hDEADBEEF at T+3; busy high at T+1 and T+2.
- Simultaneous writes: req0 and req1 both high, addr0=8'h04/wdata0=32'h11, addr1=8'h08/wdata1=32'h22.
  -> requester 0 granted at T+1 and requester 1 at T+3.
  -> Repeat with both requesting again: requester 1 goes first if last==0.
  -> With PRIORIDADE_FIXA_CPU_EN defined, requester 0 is always first.
- Misaligned access: req1=1, type1=10, addr1=8'h06.
  -> err1 at T+1; no mem_we or mem_re; req0 issued at T+1 is granted at T+2.
- Reset mid-read: drive reset=0 during RWAIT.
  -> no rvalid0; all outputs 0 the next cycle; first post-reset simultaneous request grants requester 0.
- Back-to-back reads from requester 1: addr1=8'h00, then 8'h04.
  -> rvalid1 pulses 3 cycles apart; the second gnt1 coincides with the first rvalid1 cycle +1; no gnt and err in the same cycle.

Source files
------------

// File: rtl/arbitro_memoria_dados.sv
// -----------------------------------------------------------------------------
// arbitro_memoria_dados
//
// Two-requester arbiter in front of the single data-memory port.
//   requester 0 : processor load/store path (stalls on gnt0_o / rvalid0_o)
//   requester 1 : auxiliary master (display scanner / I/O copy engine)
//
// One access is in flight at a time. A request sampled in IDLE is validated
// for size/alignment; a legal one is registered onto the memory command port
// (visible for one CMD cycle together with the matching grant pulse), and a
// read returns mem_rdata_i to the owner with a one-cycle rvalid pulse on the
// first IDLE cycle after RWAIT. Illegal requests get a one-cycle err pulse.
//
// Arbitration: round-robin on the last served requester (requester 0 first
// after reset). Defining PRIORIDADE_FIXA_CPU_EN selects fixed priority with
// requester 0 always winning; the round-robin pointer is still maintained.
//
// Ports
//   clk_i                  system clock, all logic on the rising edge
//   reset_i                synchronous reset, active low
//   reqN_i/weN_i/addrN_i/wdataN_i/typeN_i   request N (held until gnt/err)
//   gntN_o                 command of requester N is on the memory port
//   errN_o                 request N rejected (bad size or misaligned)
//   rvalidN_o/rdataN_o     read data return to requester N
//   mem_addr_o/mem_wdata_o/mem_type_o       registered memory command
//   mem_we_o/mem_re_o      one-cycle write/read strobes
//   mem_rdata_i            read data, valid the cycle after mem_re_o
//   busy_o                 arbiter not in IDLE
// -----------------------------------------------------------------------------
module arbitro_memoria_dados #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,

    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [1:0]        type0_i,
    output logic              gnt0_o,
    output logic              err0_o,
    output logic              rvalid0_o,
    output logic [DATA_W-1:0] rdata0_o,

    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic [1:0]        type1_i,
    output logic              gnt1_o,
    output logic              err1_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata1_o,

    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [1:0]        mem_type_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_RWAIT = 2'd2
    } state_t;

    // Requester fields gathered into vectors so both sides share one datapath.
    logic [1:0]                    req_w;
    logic [1:0]                    we_w;
    logic [1:0][ADDR_W-1:0]        addr_w;
    logic [1:0][DATA_W-1:0]        wdata_w;
    logic [1:0][1:0]               type_w;
    logic [1:0]                    legal_w;

    assign req_w   = {req1_i, req0_i};
    assign we_w    = {we1_i, we0_i};
    assign addr_w  = {addr1_i, addr0_i};
    assign wdata_w = {wdata1_i, wdata0_i};
    assign type_w  = {type1_i, type0_i};

    // Size/alignment check per requester: bytes always legal, halves need an
    // even address, words need a 4-byte aligned address, size 11 is reserved.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_legal
            assign legal_w[gi] = (type_w[gi] == 2'b00) ||
                                 ((type_w[gi] == 2'b01) && !addr_w[gi][0]) ||
                                 ((type_w[gi] == 2'b10) && (addr_w[gi][1:0] == 2'b00));
        end
    endgenerate

    // State and registered outputs.
    state_t                 state_q, state_d;
    logic                   last_q, last_d;   // last requester served or rejected
    logic                   own_q, own_d;     // owner of the access in flight
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic [1:0]             mem_type_q, mem_type_d;
    logic                   mem_we_q, mem_we_d;
    logic                   mem_re_q, mem_re_d;
    logic [1:0]             gnt_q, gnt_d;
    logic [1:0]             err_q, err_d;
    logic [1:0]             rvalid_q, rvalid_d;
    logic [1:0][DATA_W-1:0] rdata_q, rdata_d;

    // Winner of the current IDLE sample. With a single requester it always
    // wins; with both, the selection rule depends on the build option.
    logic sel;

    always_comb begin
        sel = ~req_w[0];
`ifdef PRIORIDADE_FIXA_CPU_EN
        // Requester 0 wins whenever it asks; requester 1 only when it is alone.
        sel = ~req_w[0];
`else
        if (&req_w) begin
            sel = ~last_q;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        own_d       = own_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_type_d  = mem_type_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        gnt_d       = 2'b00;
        err_d       = 2'b00;
        rvalid_d    = 2'b00;
        rdata_d     = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (|req_w) begin
                    last_d = sel;
                    if (legal_w[sel]) begin
                        own_d       = sel;
                        mem_addr_d  = addr_w[sel];
                        mem_wdata_d = wdata_w[sel];
                        mem_type_d  = type_w[sel];
                        mem_we_d    = we_w[sel];
                        mem_re_d    = ~we_w[sel];
                        gnt_d[sel]  = 1'b1;
                        state_d     = ST_CMD;
                    end else begin
                        // Rejection costs one cycle; arbitration continues
                        // in the cycle the err pulse is visible.
                        err_d[sel] = 1'b1;
                    end
                end
            end

            ST_CMD: begin
                // Strobes fall back to their default 0 on the way out.
                state_d = mem_we_q ? ST_IDLE : ST_RWAIT;
            end

            ST_RWAIT: begin
                // Memory answers one cycle after mem_re; only the owner's
                // data register is touched.
                rdata_d[own_q]  = mem_rdata_i;
                rvalid_d[own_q] = 1'b1;
                state_d         = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            own_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_type_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            gnt_q       <= '0;
            err_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            own_q       <= own_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_type_q  <= mem_type_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            gnt_q       <= gnt_d;
            err_q       <= err_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign gnt0_o      = gnt_q[0];
    assign gnt1_o      = gnt_q[1];
    assign err0_o      = err_q[0];
    assign err1_o      = err_q[1];
    assign rvalid0_o   = rvalid_q[0];
    assign rvalid1_o   = rvalid_q[1];
    assign rdata0_o    = rdata_q[0];
    assign rdata1_o    = rdata_q[1];
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_type_o  = mem_type_q;
    assign mem_we_o    = mem_we_q;
    assign mem_re_o    = mem_re_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// -----------------------------------------------------------------------------
// Testbench for arbitro_memoria_dados.
// A timeline model predicts, for every cycle, the arbiter's outputs from the
// request rules (who wins, legality, fixed latencies) and a word memory; a
// negedge process compares the DUT against it. Directed stimulus adds
// literal expectations at the key cycles of each scenario.
// -----------------------------------------------------------------------------
module tb_arbitro_memoria_dados;

    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int MAXC = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [1:0]    type0, type1;
    logic          gnt0, err0, rvalid0, gnt1, err1, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [1:0]    mem_type;
    logic          mem_we, mem_re, busy;
    logic [DW-1:0] mem_rdata = '0;

    arbitro_memoria_dados #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk), .reset_i(reset),
        .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0), .type0_i(type0),
        .gnt0_o(gnt0), .err0_o(err0), .rvalid0_o(rvalid0), .rdata0_o(rdata0),
        .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1), .type1_i(type1),
        .gnt1_o(gnt1), .err1_o(err1), .rvalid1_o(rvalid1), .rdata1_o(rdata1),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_type_o(mem_type),
        .mem_we_o(mem_we), .mem_re_o(mem_re), .mem_rdata_i(mem_rdata),
        .busy_o(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
        checks++;
        if (act !== exv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exv);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'hA0A0_0000;
            1:       return 32'h0000_B1B1;
            4:       return 32'hDEAD_BEEF;
            default: return 32'h1000_0000 + i;
        endcase
    endfunction

    // Memory attached to the port: whole-word write, one-cycle registered read.
    logic [31:0] bmem [64];
    initial begin
        for (int i = 0; i < 64; i++) bmem[i] = init_word(i);
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (mem_re === 1'b1) mem_rdata <= bmem[mem_addr[7:2]];
            if (mem_we === 1'b1) bmem[mem_addr[7:2]] = mem_wdata;
        end
    end

    // ---------------- timeline model ----------------
    typedef struct packed {
        bit          g0, g1, e0, e1, rv0, rv1, we, re, bsy, cmd, clr;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [1:0]  ty;
        logic [31:0] rd;
    } exp_t;

    exp_t        ex [MAXC];
    logic [31:0] mm [64];
    int          nxt_arb = 0;
    bit          lst     = 1'b1;
    bit          armed   = 1'b0;
    logic [7:0]  c_addr;
    logic [31:0] c_wd, c_rd0, c_rd1;
    logic [1:0]  c_ty;

    initial begin
        for (int i = 0; i < 64; i++) mm[i] = init_word(i);
        for (int i = 0; i < MAXC; i++) ex[i] = '0;
        forever begin
            @(negedge clk);
            if (cyc + 4 < MAXC) begin
                if (armed) begin
                    if (ex[cyc].clr) begin
                        c_addr = '0; c_wd = '0; c_ty = '0; c_rd0 = '0; c_rd1 = '0;
                    end
                    if (ex[cyc].cmd) begin
                        c_addr = ex[cyc].addr; c_wd = ex[cyc].wd; c_ty = ex[cyc].ty;
                    end
                    if (ex[cyc].rv0) c_rd0 = ex[cyc].rd;
                    if (ex[cyc].rv1) c_rd1 = ex[cyc].rd;
                    chk("gnt0", gnt0, ex[cyc].g0);
                    chk("gnt1", gnt1, ex[cyc].g1);
                    chk("err0", err0, ex[cyc].e0);
                    chk("err1", err1, ex[cyc].e1);
                    chk("rvalid0", rvalid0, ex[cyc].rv0);
                    chk("rvalid1", rvalid1, ex[cyc].rv1);
                    chk("mem_we", mem_we, ex[cyc].we);
                    chk("mem_re", mem_re, ex[cyc].re);
                    chk("busy", busy, ex[cyc].bsy);
                    chk("mem_addr", mem_addr, c_addr);
                    chk("mem_wdata", mem_wdata, c_wd);
                    chk("mem_type", mem_type, c_ty);
                    chk("rdata0", rdata0, c_rd0);
                    chk("rdata1", rdata1, c_rd1);
                end
                if (reset === 1'b0) begin
                    armed = 1'b1;
                    for (int j = cyc + 1; j <= cyc + 3; j++) ex[j] = '0;
                    ex[cyc+1].clr = 1'b1;
                    nxt_arb = cyc + 1;
                    lst     = 1'b1;
                end else if (armed && cyc >= nxt_arb && (req0 || req1)) begin
                    bit         w;
                    bit         wwe;
                    logic [7:0] wa;
                    logic [31:0] wd;
                    logic [1:0] wt;
                    bit         ok;
                    if (req0 && req1) begin
`ifdef PRIORIDADE_FIXA_CPU_EN
                        w = 1'b0;
`else
                        w = (lst == 1'b1) ? 1'b0 : 1'b1;
`endif
                    end else begin
                        w = req1;
                    end
                    lst = w;
                    wwe = w ? we1 : we0;
                    wa  = w ? addr1 : addr0;
                    wd  = w ? wdata1 : wdata0;
                    wt  = w ? type1 : type0;
                    ok  = (wt != 2'd3) && ((int'(wa) % (1 << wt)) == 0);
                    if (!ok) begin
                        if (w) ex[cyc+1].e1 = 1'b1; else ex[cyc+1].e0 = 1'b1;
                        nxt_arb = cyc + 1;
                    end else begin
                        ex[cyc+1].cmd  = 1'b1;
                        ex[cyc+1].addr = wa;
                        ex[cyc+1].wd   = wd;
                        ex[cyc+1].ty   = wt;
                        ex[cyc+1].bsy  = 1'b1;
                        if (w) ex[cyc+1].g1 = 1'b1; else ex[cyc+1].g0 = 1'b1;
                        if (wwe) begin
                            ex[cyc+1].we = 1'b1;
                            mm[wa[7:2]]  = wd;
                            nxt_arb      = cyc + 2;
                        end else begin
                            ex[cyc+1].re  = 1'b1;
                            ex[cyc+2].bsy = 1'b1;
                            ex[cyc+3].rd  = mm[wa[7:2]];
                            if (w) ex[cyc+3].rv1 = 1'b1; else ex[cyc+3].rv0 = 1'b1;
                            nxt_arb = cyc + 3;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Requesters drop their request in the cycle they see gnt or err.
    task automatic tick();
        @(posedge clk);
        #1;
        if (gnt0 === 1'b1 || err0 === 1'b1) req0 = 1'b0;
        if (gnt1 === 1'b1 || err1 === 1'b1) req1 = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rq0(input bit w, input logic [7:0] a, input logic [31:0] d, input logic [1:0] t);
        req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; type0 = t;
    endtask

    task automatic rq1(input bit w, input logic [7:0] a, input logic [31:0] d, input logic [1:0] t);
        req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; type1 = t;
    endtask

    initial begin
        reset = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; type0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; type1 = '0;
        ticks(3);
        chk("reset_busy", busy, 0);
        chk("reset_gnt0", gnt0, 0);
        chk("reset_rdata0", rdata0, 0);
        chk("reset_mem_re", mem_re, 0);
        reset = 1'b1;
        tick();

        // Single read by requester 0.
        rq0(0, 8'h10, 32'h0, 2'b10);
        tick();
        chk("rd_gnt0", gnt0, 1);
        chk("rd_mem_re", mem_re, 1);
        chk("rd_mem_addr", mem_addr, 32'h10);
        chk("rd_busy1", busy, 1);
        tick();
        chk("rd_busy2", busy, 1);
        tick();
        chk("rd_rvalid0", rvalid0, 1);
        chk("rd_rdata0", rdata0, 32'hDEADBEEF);
        tick();
        chk("rd_rvalid0_off", rvalid0, 0);
        chk("rd_rdata0_hold", rdata0, 32'hDEADBEEF);

        // Fresh reset so both-requesting starts from last==1.
        reset = 1'b0;
        ticks(2);
        reset = 1'b1;
        tick();

        // Simultaneous writes.
        rq0(1, 8'h04, 32'h11, 2'b10);
        rq1(1, 8'h08, 32'h22, 2'b10);
        tick();
        chk("ww_gnt0", gnt0, 1);
        chk("ww_gnt1_lose", gnt1, 0);
        chk("ww_mem_we", mem_we, 1);
        chk("ww_wdata0", mem_wdata, 32'h11);
        tick();
        chk("ww_we_clear", mem_we, 0);
        tick();
        chk("ww_gnt1", gnt1, 1);
        chk("ww_addr1", mem_addr, 32'h08);
        chk("ww_wdata1", mem_wdata, 32'h22);
        tick();
        // Requester 0 alone leaves last==0, then both ask again.
        rq0(1, 8'h0C, 32'h33, 2'b10);
        tick();
        chk("solo_gnt0", gnt0, 1);
        tick();
        rq0(1, 8'h14, 32'h44, 2'b10);
        rq1(1, 8'h18, 32'h55, 2'b10);
        tick();
`ifdef PRIORIDADE_FIXA_CPU_EN
        chk("rr_first_gnt0", gnt0, 1);
`else
        chk("rr_first_gnt1", gnt1, 1);
`endif
        ticks(2);
`ifdef PRIORIDADE_FIXA_CPU_EN
        chk("rr_second_gnt1", gnt1, 1);
`else
        chk("rr_second_gnt0", gnt0, 1);
`endif
        tick();

        // Misaligned word from requester 1, then requester 0 read.
        rq1(0, 8'h06, 32'h0, 2'b10);
        tick();
        chk("mis_err1", err1, 1);
        chk("mis_no_we", mem_we, 0);
        chk("mis_no_re", mem_re, 0);
        rq0(0, 8'h00, 32'h0, 2'b10);
        tick();
        chk("mis_gnt0", gnt0, 1);
        ticks(2);
        chk("mis_rdata0", rdata0, 32'hA0A00000);

        // Odd half and reserved size rejected, odd byte accepted.
        rq0(1, 8'h03, 32'h77, 2'b01);
        tick();
        chk("half_odd_err0", err0, 1);
        rq0(1, 8'h21, 32'h66, 2'b11);
        tick();
        chk("rsv_err0", err0, 1);
        rq0(1, 8'h23, 32'h99, 2'b00);
        tick();
        chk("byte_gnt0", gnt0, 1);
        chk("byte_type", mem_type, 0);
        tick();
        rq1(0, 8'h22, 32'h0, 2'b01);
        ticks(3);
        chk("half_rvalid1", rvalid1, 1);
        chk("half_rdata1", rdata1, 32'h99);
        tick();

        // Reset during RWAIT aborts the read.
        rq0(0, 8'h10, 32'h0, 2'b10);
        ticks(2);
        reset = 1'b0;
        tick();
        chk("abort_rvalid0", rvalid0, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rdata0", rdata0, 0);
        chk("abort_mem_addr", mem_addr, 0);
        reset = 1'b1;
        tick();
        rq0(1, 8'h30, 32'hAA, 2'b10);
        rq1(1, 8'h34, 32'hBB, 2'b10);
        tick();
        chk("post_rst_gnt0", gnt0, 1);
        ticks(3);

        // Back-to-back reads from requester 1.
        rq1(0, 8'h00, 32'h0, 2'b10);
        tick();
        chk("b2b_gnt1_a", gnt1, 1);
        rq1(0, 8'h04, 32'h0, 2'b10);
        ticks(2);
        chk("b2b_rvalid1_a", rvalid1, 1);
        chk("b2b_rdata1_a", rdata1, 32'hA0A00000);
        tick();
        chk("b2b_gnt1_b", gnt1, 1);
        chk("b2b_addr_b", mem_addr, 32'h04);
        ticks(2);
        chk("b2b_rvalid1_b", rvalid1, 1);
        chk("b2b_rdata1_b", rdata1, 32'h11);
        chk("b2b_rdata0_kept", rdata0, 0);
        ticks(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
